// File: rtl/lsu_rmw.sv
// Load/store unit between an RV32I core and a word-wide, byte-enable-less data memory.
// Sub-word loads are extracted and extended; sub-word stores use a read-modify-write.
module lsu_rmw #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {StIdle, StLoadWait, StRmwMerge} state_e;

  localparam logic [33:0] AddrLimit = 34'(MEM_WORDS) * 34'd4;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  size_q, size_d;

  logic size_ok, out_of_range, req_err;

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lane,
                                        input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    if (size[0]) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end else begin
      m[{lane, 3'b000} +: 8] = wd[7:0];
    end
    merge = m;
  endfunction

  always_comb begin
    size_ok      = core_size_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    out_of_range = RANGE_CHECK && ({2'b00, core_addr_i} >= AddrLimit);
    req_err      = !size_ok
                || (core_size_i[2] && core_we_i)
                || (core_size_i[1:0] == 2'b01 && core_addr_i[0])
                || (core_size_i == 3'b010 && core_addr_i[1:0] != 2'b00)
                || out_of_range;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wd_d       = wd_q;
    core_rd_o  = '0;
    valid_o    = 1'b0;
    stall_o    = 1'b0;
    err_o      = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    // Outputs are forced low for the whole reset, including the IDLE bypass path.
    if (rst_ni) begin
      unique case (state_q)
        StIdle: begin
          if (core_req_i) begin
            addr_d = core_addr_i;
            size_d = core_size_i;
            wd_d   = core_wd_i;
            if (req_err) begin
              err_o = 1'b1;
            end else begin
              mem_req_o  = 1'b1;
              mem_addr_o = {core_addr_i[31:2], 2'b00};
              if (core_we_i && core_size_i == 3'b010) begin
                mem_we_o = 1'b1;
                mem_wd_o = core_wd_i;
                valid_o  = 1'b1;
              end else begin
                stall_o = 1'b1;
                state_d = core_we_i ? StRmwMerge : StLoadWait;
              end
            end
          end
        end
        StLoadWait: begin
          core_rd_o = load_ext(mem_rd_i, addr_q[1:0], size_q);
          valid_o   = 1'b1;
          state_d   = StIdle;
        end
        StRmwMerge: begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = {addr_q[31:2], 2'b00};
          mem_wd_o   = merge(mem_rd_i, addr_q[1:0], size_q, wd_q);
          valid_o    = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wd_q    <= wd_d;
    end
  end

endmodule
